// File: rtl/tt_nibble_pkg.sv
// Shared sizing constants and assembler state type for the nibble unpacker.
// Build option: NIBBLE_UNPACKER_INVERT_EN selects inverted nibble decoding in the top.
package tt_nibble_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } asm_state_t;

endpackage

// File: rtl/nibble_fifo_if.sv
// Byte-wide push/pop bus between the nibble assembler (master) and its FIFO (slave).
interface nibble_fifo_if;
    import tt_nibble_pkg::*;

    logic             push;
    logic             pop;
    logic [7:0]       din;
    logic [7:0]       dout;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (output push, output pop, output din,
                    input  dout, input count, input full, input empty);
    modport slave  (input  push, input pop, input din,
                    output dout, output count, output full, output empty);

endinterface

// File: rtl/nibble_fifo.sv
// Four-entry byte FIFO with a registered head output that reads 8'h00 when empty.
// A pop is applied before a same-cycle push, so a full FIFO accepts pop+push together.
module nibble_fifo
    import tt_nibble_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    nibble_fifo_if.slave f
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [7:0]       dout_reg, dout_next;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop      = f.pop && (count_reg != '0);
        do_push     = f.push && ((count_reg != CNT_W'(FIFO_DEPTH)) || do_pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
        count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        // The head is the incoming byte only when it lands in an otherwise empty FIFO.
        if (count_next == '0) begin
            dout_next = 8'h00;
        end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            dout_next = f.din;
        end else begin
            dout_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= f.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= 8'h00;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

    assign f.dout  = dout_reg;
    assign f.count = count_reg;
    assign f.full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign f.empty = (count_reg == '0);

endmodule

// File: rtl/tt_um_nibble_unpacker.sv
// Nibble-to-byte unpacker: synchronised strobes, two-nibble assembler, 4-byte FIFO.
// Build option: NIBBLE_UNPACKER_INVERT_EN inverts each received nibble before assembly.
module tt_um_nibble_unpacker
    import tt_nibble_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    // Channel 0: nibble strobe, 1: pop strobe, 2: overflow clear (level only).
    logic [2:0] sync_in;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;
    logic [1:0] prev_reg;
    logic [1:0] rise;

    assign sync_in = {ui_in[1], ui_in[0], uio_in[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else if (ena) begin
            sync1_reg <= sync_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg[1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rise
            assign rise[gi] = sync2_reg[gi] & ~prev_reg[gi];
        end
    endgenerate

    logic       nib_ev;
    logic       pop_ev;
    logic       clr_lvl;
    logic [3:0] nibble;

    assign nib_ev  = ena & rise[0];
    assign pop_ev  = ena & rise[1];
    assign clr_lvl = sync2_reg[2];

`ifdef NIBBLE_UNPACKER_INVERT_EN
    assign nibble = ~uio_in[3:0];
`else
    assign nibble = uio_in[3:0];
`endif

    nibble_fifo_if fifo_bus ();

    nibble_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (fifo_bus.slave)
    );

    asm_state_t state_reg;
    logic [3:0] low_nib_reg;
    logic       ovf_reg;
    logic       ovf_set;

    // First nibble becomes the low half; the second completes the byte and pushes it.
    assign fifo_bus.push = nib_ev && (state_reg == HIGH);
    assign fifo_bus.pop  = pop_ev;
    assign fifo_bus.din  = {nibble, low_nib_reg};
    assign ovf_set       = fifo_bus.push && fifo_bus.full && !pop_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LOW;
            low_nib_reg <= 4'h0;
            ovf_reg     <= 1'b0;
        end else if (ena) begin
            if (nib_ev) begin
                if (state_reg == LOW) begin
                    low_nib_reg <= nibble;
                    state_reg   <= HIGH;
                end else begin
                    state_reg   <= LOW;
                end
            end
            // A new overflow wins over a clear seen in the same cycle.
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (clr_lvl) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign uo_out  = fifo_bus.dout;
    assign uio_out = {ovf_reg, fifo_bus.empty, ~fifo_bus.full, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

    logic unused;
    assign unused = &{1'b0, ui_in[7:2], uio_in[7:5], fifo_bus.count};

endmodule
